// File: rtl/dense_engine_if.sv
// dense_engine_if -- handshake and memory-port bundle for dense_engine.
//
// Signals:
//   start            request to begin a layer pass
//   busy, done       pass in progress / one-cycle completion pulse
//   inAdr, inData    input activation buffer (combinational read)
//   weightAdr/Data   weight LUT, LANES packed lanes of DATA_SIZE bits
//   biasAdr/Data     bias LUT, same lane packing
//   outAdr/Data/Wr   output buffer write port
// Modports: master = engine side, slave = memories / environment side.
interface dense_engine_if #(
  parameter int IN_COUNT  = 784,
  parameter int OUT_COUNT = 10,
  parameter int DATA_SIZE = 16,
  parameter int LANES     = 2
);
  localparam int GROUPS = OUT_COUNT / LANES;
  localparam int IN_AW  = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;
  localparam int WT_AW  = (IN_COUNT * GROUPS > 1) ? $clog2(IN_COUNT * GROUPS) : 1;
  localparam int GRP_AW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int OUT_AW = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;

  logic                         start;
  logic                         busy;
  logic                         done;
  logic [IN_AW-1:0]             inAdr;
  logic [DATA_SIZE-1:0]         inData;
  logic [WT_AW-1:0]             weightAdr;
  logic [LANES*DATA_SIZE-1:0]   weightData;
  logic [GRP_AW-1:0]            biasAdr;
  logic [LANES*DATA_SIZE-1:0]   biasData;
  logic [OUT_AW-1:0]            outAdr;
  logic [DATA_SIZE-1:0]         outData;
  logic                         outWr;

  modport master (
    input  start, inData, weightData, biasData,
    output busy, done, inAdr, weightAdr, biasAdr, outAdr, outData, outWr
  );

  modport slave (
    output start, inData, weightData, biasData,
    input  busy, done, inAdr, weightAdr, biasAdr, outAdr, outData, outWr
  );
endinterface

// File: rtl/dense_engine.sv
// dense_engine -- fully connected layer engine with LANES parallel MAC lanes.
//
// Each pass walks GROUPS groups of LANES output neurons. For each group the
// lanes accumulate inData * weight over all inputs, add the bias, then the
// lane results are shifted right by FRAC_BITS, saturated to DATA_SIZE and
// written to the output buffer one lane per cycle.
//
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  dense_engine_if.master (start/busy/done, input, weight, bias and
//        output buffer ports)
//
// Build option: define DENSE_ENGINE_RELU_EN to clamp negative results to 0
// after saturation; without it signed saturated results are written as-is.
module dense_engine #(
  parameter int IN_COUNT  = 784,
  parameter int OUT_COUNT = 10,
  parameter int DATA_SIZE = 16,
  parameter int LANES     = 2,
  parameter int FRAC_BITS = 8
) (
  input  logic           clk,
  input  logic           rst,
  dense_engine_if.master bus
);

  // state | meaning
  // IDLE  | waiting for start
  // MAC   | one input per cycle, every lane multiply-accumulates
  // BIAS  | one cycle, every lane adds its bias
  // WRITE | LANES cycles, lane k written to outAdr group*LANES+k
  // FIN   | done pulse, back to IDLE
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_BIAS  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam int GROUPS  = OUT_COUNT / LANES;
  localparam int DS      = DATA_SIZE;
  localparam int IN_AW   = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;
  localparam int WT_AW   = (IN_COUNT * GROUPS > 1) ? $clog2(IN_COUNT * GROUPS) : 1;
  localparam int GRP_AW  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int OUT_AW  = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam int LANE_AW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ACC_W   = 2 * DS + $clog2(IN_COUNT) + 1;

  localparam logic [IN_AW-1:0]   IN_LAST   = IN_AW'(IN_COUNT - 1);
  localparam logic [GRP_AW-1:0]  GRP_LAST  = GRP_AW'(GROUPS - 1);
  localparam logic [LANE_AW-1:0] LANE_LAST = LANE_AW'(LANES - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DS+1){1'b0}}, {(DS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DS+1){1'b1}}, {(DS-1){1'b0}}};

  logic [2:0]               r_state;
  logic [IN_AW-1:0]         r_in_cnt;
  logic [GRP_AW-1:0]        r_grp;
  logic [LANE_AW-1:0]       r_lane;
  logic signed [ACC_W-1:0]  r_acc [LANES];

  logic signed [DS-1:0]     w_act;
  logic signed [DS-1:0]     w_wt       [LANES];
  logic signed [DS-1:0]     w_bias     [LANES];
  logic signed [2*DS-1:0]   w_prod     [LANES];
  logic signed [ACC_W-1:0]  w_prod_ext [LANES];
  logic signed [ACC_W-1:0]  w_bias_ext [LANES];
  logic signed [ACC_W-1:0]  w_sel;
  logic signed [ACC_W-1:0]  w_shift;
  logic [DS-1:0]            w_sat;
  logic [DS-1:0]            w_out;

  assign w_act = bus.inData;

  // Per-lane unpacking and sign extension into accumulator width.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_wt[l]       = bus.weightData[l*DS +: DS];
      w_bias[l]     = bus.biasData[l*DS +: DS];
      w_prod[l]     = w_act * w_wt[l];
      w_prod_ext[l] = {{(ACC_W-2*DS){w_prod[l][2*DS-1]}}, w_prod[l]};
      w_bias_ext[l] = {{(ACC_W-DS){w_bias[l][DS-1]}}, w_bias[l]};
    end
  end

  // Lane currently being written.
  always_comb begin
    w_sel = r_acc[0];
    for (int l = 1; l < LANES; l++) begin
      if (r_lane == LANE_AW'(l)) w_sel = r_acc[l];
    end
  end

  // Arithmetic shift floors toward minus infinity; saturation is judged on
  // the full-width shifted value before narrowing.
  assign w_shift = w_sel >>> FRAC_BITS;

  always_comb begin
    if (w_shift > SAT_MAX)      w_sat = {1'b0, {(DS-1){1'b1}}};
    else if (w_shift < SAT_MIN) w_sat = {1'b1, {(DS-1){1'b0}}};
    else                        w_sat = w_shift[DS-1:0];
  end

`ifdef DENSE_ENGINE_RELU_EN
  assign w_out = w_sat[DS-1] ? '0 : w_sat;
`else
  assign w_out = w_sat;
`endif

  assign bus.busy      = (r_state == S_MAC) || (r_state == S_BIAS) || (r_state == S_WRITE);
  assign bus.done      = (r_state == S_FIN);
  assign bus.outWr     = (r_state == S_WRITE);
  assign bus.inAdr     = r_in_cnt;
  // Group strides are in-range whenever they matter (a single group keeps
  // r_grp and the stride products at zero), so truncating casts are safe.
  assign bus.weightAdr = WT_AW'(r_in_cnt) * WT_AW'(GROUPS) + WT_AW'(r_grp);
  assign bus.biasAdr   = r_grp;
  assign bus.outAdr    = OUT_AW'(r_grp) * OUT_AW'(LANES) + OUT_AW'(r_lane);
  assign bus.outData   = w_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_in_cnt <= '0;
      r_grp    <= '0;
      r_lane   <= '0;
      for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_in_cnt <= '0;
            r_grp    <= '0;
            r_lane   <= '0;
            for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
            r_state  <= S_MAC;
          end
        end
        S_MAC: begin
          for (int l = 0; l < LANES; l++) r_acc[l] <= r_acc[l] + w_prod_ext[l];
          if (r_in_cnt == IN_LAST) begin
            r_in_cnt <= '0;
            r_state  <= S_BIAS;
          end else begin
            r_in_cnt <= r_in_cnt + IN_AW'(1);
          end
        end
        S_BIAS: begin
          for (int l = 0; l < LANES; l++) r_acc[l] <= r_acc[l] + w_bias_ext[l];
          r_lane  <= '0;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (r_lane == LANE_LAST) begin
            r_lane <= '0;
            if (r_grp != GRP_LAST) begin
              r_grp    <= r_grp + GRP_AW'(1);
              r_in_cnt <= '0;
              for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
              r_state  <= S_MAC;
            end else begin
              r_state <= S_FIN;
            end
          end else begin
            r_lane <= r_lane + LANE_AW'(1);
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_engine.sv
// tb_dense_engine -- self-checking bench for dense_engine.
// Three instances: A (4 in, 2 out, 2 lanes, 16-bit, no fraction),
// B (4 in, 4 out, 2 lanes, 8-bit, no fraction),
// C (1 in, 3 out, 3 lanes, 16-bit, 3 fraction bits).
// Expected outputs come from a weight-matrix model: out[o] = post(bias[o] +
// sum_i in[i]*W[i][o]); the memory contents are derived from the same matrix.
module tb_dense_engine;

  localparam int A_IN = 4, A_OUT = 2, A_L = 2, A_DS = 16, A_F = 0, A_G = A_OUT / A_L;
  localparam int B_IN = 4, B_OUT = 4, B_L = 2, B_DS = 8,  B_F = 0, B_G = B_OUT / B_L;
  localparam int C_IN = 1, C_OUT = 3, C_L = 3, C_DS = 16, C_F = 3, C_G = C_OUT / C_L;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  dense_engine_if #(.IN_COUNT(A_IN), .OUT_COUNT(A_OUT), .DATA_SIZE(A_DS), .LANES(A_L)) ifa ();
  dense_engine_if #(.IN_COUNT(B_IN), .OUT_COUNT(B_OUT), .DATA_SIZE(B_DS), .LANES(B_L)) ifb ();
  dense_engine_if #(.IN_COUNT(C_IN), .OUT_COUNT(C_OUT), .DATA_SIZE(C_DS), .LANES(C_L)) ifc ();

  dense_engine #(.IN_COUNT(A_IN), .OUT_COUNT(A_OUT), .DATA_SIZE(A_DS), .LANES(A_L), .FRAC_BITS(A_F))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dense_engine #(.IN_COUNT(B_IN), .OUT_COUNT(B_OUT), .DATA_SIZE(B_DS), .LANES(B_L), .FRAC_BITS(B_F))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  dense_engine #(.IN_COUNT(C_IN), .OUT_COUNT(C_OUT), .DATA_SIZE(C_DS), .LANES(C_L), .FRAC_BITS(C_F))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int a_in [A_IN];  int a_w [A_IN][A_OUT];  int a_b [A_OUT];
  int b_in [B_IN];  int b_w [B_IN][B_OUT];  int b_b [B_OUT];
  int c_in [C_IN];  int c_w [C_IN][C_OUT];  int c_b [C_OUT];

  // Memory models: weight word i*G+g holds outputs g*L .. g*L+L-1 of input i.
  always_comb begin
    ifa.inData = '0; ifa.weightData = '0; ifa.biasData = '0;
    if (int'(ifa.inAdr) < A_IN) ifa.inData = A_DS'(a_in[int'(ifa.inAdr)]);
    for (int l = 0; l < A_L; l++) begin
      if (int'(ifa.weightAdr) < A_IN * A_G)
        ifa.weightData[l*A_DS +: A_DS] =
          A_DS'(a_w[int'(ifa.weightAdr) / A_G][(int'(ifa.weightAdr) % A_G) * A_L + l]);
      if (int'(ifa.biasAdr) < A_G) ifa.biasData[l*A_DS +: A_DS] = A_DS'(a_b[int'(ifa.biasAdr) * A_L + l]);
    end
  end

  always_comb begin
    ifb.inData = '0; ifb.weightData = '0; ifb.biasData = '0;
    if (int'(ifb.inAdr) < B_IN) ifb.inData = B_DS'(b_in[int'(ifb.inAdr)]);
    for (int l = 0; l < B_L; l++) begin
      if (int'(ifb.weightAdr) < B_IN * B_G)
        ifb.weightData[l*B_DS +: B_DS] =
          B_DS'(b_w[int'(ifb.weightAdr) / B_G][(int'(ifb.weightAdr) % B_G) * B_L + l]);
      if (int'(ifb.biasAdr) < B_G) ifb.biasData[l*B_DS +: B_DS] = B_DS'(b_b[int'(ifb.biasAdr) * B_L + l]);
    end
  end

  always_comb begin
    ifc.inData = '0; ifc.weightData = '0; ifc.biasData = '0;
    if (int'(ifc.inAdr) < C_IN) ifc.inData = C_DS'(c_in[int'(ifc.inAdr)]);
    for (int l = 0; l < C_L; l++) begin
      if (int'(ifc.weightAdr) < C_IN * C_G)
        ifc.weightData[l*C_DS +: C_DS] =
          C_DS'(c_w[int'(ifc.weightAdr) / C_G][(int'(ifc.weightAdr) % C_G) * C_L + l]);
      if (int'(ifc.biasAdr) < C_G) ifc.biasData[l*C_DS +: C_DS] = C_DS'(c_b[int'(ifc.biasAdr) * C_L + l]);
    end
  end

  // Output-buffer write capture, sampled mid-cycle.
  int a_adr[$], a_dat[$], b_adr[$], b_dat[$], c_adr[$], c_dat[$];
  always @(negedge clk) begin
    if (ifa.outWr === 1'b1) begin a_adr.push_back(int'(ifa.outAdr)); a_dat.push_back(int'($signed(ifa.outData))); end
    if (ifb.outWr === 1'b1) begin b_adr.push_back(int'(ifb.outAdr)); b_dat.push_back(int'($signed(ifb.outData))); end
    if (ifc.outWr === 1'b1) begin c_adr.push_back(int'(ifc.outAdr)); c_dat.push_back(int'($signed(ifc.outData))); end
  end

  // Reference: floor-divide by 2^f, clamp to ds-bit signed range, optional ReLU.
  function automatic int post(longint v, int f, int ds);
    longint d  = longint'(1) << f;
    longint hi = (longint'(1) << (ds - 1)) - 1;
    longint lo = -(longint'(1) << (ds - 1));
    longint q;
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
`ifdef DENSE_ENGINE_RELU_EN
    if (q < 0) q = 0;
`endif
    return int'(q);
  endfunction

  function automatic int exp_a(int o);
    longint acc = longint'(a_b[o]);
    for (int i = 0; i < A_IN; i++) acc += longint'(a_in[i]) * longint'(a_w[i][o]);
    return post(acc, A_F, A_DS);
  endfunction

  function automatic int exp_b(int o);
    longint acc = longint'(b_b[o]);
    for (int i = 0; i < B_IN; i++) acc += longint'(b_in[i]) * longint'(b_w[i][o]);
    return post(acc, B_F, B_DS);
  endfunction

  function automatic int exp_c(int o);
    longint acc = longint'(c_b[o]);
    for (int i = 0; i < C_IN; i++) acc += longint'(c_in[i]) * longint'(c_w[i][o]);
    return post(acc, C_F, C_DS);
  endfunction

  function automatic int rnd(int lo, int hi);
    return lo + int'($urandom_range(hi - lo, 0));
  endfunction

  // One start pulse; lat = cycles from the start cycle to the done cycle.
  task automatic run_a(output int lat, output bit timeout);
    a_adr.delete(); a_dat.delete();
    @(negedge clk); ifa.start = 1'b1; lat = 0;
    @(negedge clk); ifa.start = 1'b0; lat = 1;
    while (ifa.done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    timeout = (ifa.done !== 1'b1);
  endtask

  task automatic run_b(output int lat, output bit timeout);
    b_adr.delete(); b_dat.delete();
    @(negedge clk); ifb.start = 1'b1; lat = 0;
    @(negedge clk); ifb.start = 1'b0; lat = 1;
    while (ifb.done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    timeout = (ifb.done !== 1'b1);
  endtask

  task automatic run_c(output int lat, output bit timeout);
    c_adr.delete(); c_dat.delete();
    @(negedge clk); ifc.start = 1'b1; lat = 0;
    @(negedge clk); ifc.start = 1'b0; lat = 1;
    while (ifc.done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    timeout = (ifc.done !== 1'b1);
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1; ifa.start = 1'b1; ifb.start = 1'b1; ifc.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({ifa.busy, ifa.done, ifa.outWr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_a: busy/done/outWr got %b expected 000", {ifa.busy, ifa.done, ifa.outWr});
    end
    n_checks++;
    if ({ifb.busy, ifb.done, ifb.outWr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_b: busy/done/outWr got %b expected 000", {ifb.busy, ifb.done, ifb.outWr});
    end
    n_checks++;
    if ({ifc.busy, ifc.done, ifc.outWr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_c: busy/done/outWr got %b expected 000", {ifc.busy, ifc.done, ifc.outWr});
    end
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy got %b expected 0", ifa.busy); end
  endtask

  task automatic test_basic;
    int lat; bit to;
    for (int i = 0; i < A_IN; i++) begin
      a_in[i] = i + 1;
      for (int o = 0; o < A_OUT; o++) a_w[i][o] = 1;
    end
    for (int o = 0; o < A_OUT; o++) a_b[o] = 5;
    run_a(lat, to);
    n_checks++;
    if (to || lat != 8) begin n_fail++; $display("FAIL basic_latency: got %0d (timeout %0d) expected 8", lat, to); end
    n_checks++;
    if (a_adr.size() != A_OUT) begin n_fail++; $display("FAIL basic_writes: got %0d expected %0d", a_adr.size(), A_OUT); end
    for (int k = 0; k < a_adr.size() && k < A_OUT; k++) begin
      n_checks++;
      if (a_adr[k] != k || a_dat[k] != exp_a(k)) begin
        n_fail++; $display("FAIL basic_out%0d: adr %0d data %0d expected adr %0d data %0d", k, a_adr[k], a_dat[k], k, exp_a(k));
      end
    end
  endtask

  task automatic test_negative;
    int lat; bit to;
    for (int i = 0; i < A_IN; i++) for (int o = 0; o < A_OUT; o++) a_w[i][o] = -1;
    for (int o = 0; o < A_OUT; o++) a_b[o] = 0;
    run_a(lat, to);
    n_checks++;
    if (to || a_adr.size() != A_OUT) begin n_fail++; $display("FAIL neg_writes: got %0d expected %0d", a_adr.size(), A_OUT); end
    for (int k = 0; k < a_adr.size() && k < A_OUT; k++) begin
      n_checks++;
      if (a_dat[k] != exp_a(k)) begin n_fail++; $display("FAIL neg_out%0d: data %0d expected %0d", k, a_dat[k], exp_a(k)); end
    end
  endtask

  task automatic test_random_a;
    int lat; bit to;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < A_IN; i++) begin
        a_in[i] = rnd(-200, 200);
        for (int o = 0; o < A_OUT; o++) a_w[i][o] = rnd(-50, 50);
      end
      for (int o = 0; o < A_OUT; o++) a_b[o] = rnd(-4000, 4000);
      run_a(lat, to);
      n_checks++;
      if (to || lat != 8 || a_adr.size() != A_OUT) begin
        n_fail++; $display("FAIL rand_a%0d: latency %0d writes %0d expected 8 and %0d", it, lat, a_adr.size(), A_OUT);
      end
      for (int k = 0; k < a_adr.size() && k < A_OUT; k++) begin
        n_checks++;
        if (a_adr[k] != k || a_dat[k] != exp_a(k)) begin
          n_fail++; $display("FAIL rand_a%0d_out%0d: adr %0d data %0d expected adr %0d data %0d", it, k, a_adr[k], a_dat[k], k, exp_a(k));
        end
      end
    end
  endtask

  task automatic test_saturation;
    int lat; bit to;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < B_IN; i++) begin
        b_in[i] = 127;
        for (int o = 0; o < B_OUT; o++) b_w[i][o] = (pass == 0) ? 127 : -127;
      end
      for (int o = 0; o < B_OUT; o++) b_b[o] = 0;
      run_b(lat, to);
      n_checks++;
      if (to || b_adr.size() != B_OUT) begin n_fail++; $display("FAIL sat%0d_writes: got %0d expected %0d", pass, b_adr.size(), B_OUT); end
      for (int k = 0; k < b_adr.size() && k < B_OUT; k++) begin
        n_checks++;
        if (b_dat[k] != exp_b(k)) begin n_fail++; $display("FAIL sat%0d_out%0d: data %0d expected %0d", pass, k, b_dat[k], exp_b(k)); end
      end
    end
  endtask

  task automatic test_groups;
    int lat; bit to;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < B_IN; i++) begin
        b_in[i] = rnd(-5, 5);
        for (int o = 0; o < B_OUT; o++) b_w[i][o] = rnd(-5, 5);
      end
      for (int o = 0; o < B_OUT; o++) b_b[o] = rnd(-20, 20);
      run_b(lat, to);
      n_checks++;
      if (to || lat != 15) begin n_fail++; $display("FAIL groups%0d_latency: got %0d expected 15", it, lat); end
      n_checks++;
      if (b_adr.size() != B_OUT) begin n_fail++; $display("FAIL groups%0d_writes: got %0d expected %0d", it, b_adr.size(), B_OUT); end
      for (int k = 0; k < b_adr.size() && k < B_OUT; k++) begin
        n_checks++;
        if (b_adr[k] != k || b_dat[k] != exp_b(k)) begin
          n_fail++; $display("FAIL groups%0d_out%0d: adr %0d data %0d expected adr %0d data %0d", it, k, b_adr[k], b_dat[k], k, exp_b(k));
        end
      end
    end
  endtask

  task automatic test_single_input;
    int lat; bit to;
    for (int it = 0; it < 3; it++) begin
      c_in[0] = rnd(-2000, 2000);
      for (int o = 0; o < C_OUT; o++) begin c_w[0][o] = rnd(-100, 100); c_b[o] = rnd(-5000, 5000); end
      run_c(lat, to);
      n_checks++;
      if (to || lat != 6 || c_adr.size() != C_OUT) begin
        n_fail++; $display("FAIL single%0d: latency %0d writes %0d expected 6 and %0d", it, lat, c_adr.size(), C_OUT);
      end
      for (int k = 0; k < c_adr.size() && k < C_OUT; k++) begin
        n_checks++;
        if (c_adr[k] != k || c_dat[k] != exp_c(k)) begin
          n_fail++; $display("FAIL single%0d_out%0d: adr %0d data %0d expected adr %0d data %0d", it, k, c_adr[k], c_dat[k], k, exp_c(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid_pass;
    int lat; bit to; int seen_done;
    for (int i = 0; i < A_IN; i++) begin
      a_in[i] = rnd(-100, 100);
      for (int o = 0; o < A_OUT; o++) a_w[i][o] = rnd(-30, 30);
    end
    for (int o = 0; o < A_OUT; o++) a_b[o] = rnd(-100, 100);
    a_adr.delete(); a_dat.delete();
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++;
    if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", ifa.busy); end
    seen_done = 0;
    repeat (15) begin @(negedge clk); if (ifa.done === 1'b1) seen_done++; end
    n_checks++;
    if (a_adr.size() != 0 || seen_done != 0) begin
      n_fail++; $display("FAIL midrst_quiet: writes %0d dones %0d expected 0 and 0", a_adr.size(), seen_done);
    end
    run_a(lat, to);
    n_checks++;
    if (to || lat != 8 || a_adr.size() != A_OUT) begin
      n_fail++; $display("FAIL midrst_rerun: latency %0d writes %0d expected 8 and %0d", lat, a_adr.size(), A_OUT);
    end
    for (int k = 0; k < a_adr.size() && k < A_OUT; k++) begin
      n_checks++;
      if (a_adr[k] != k || a_dat[k] != exp_a(k)) begin
        n_fail++; $display("FAIL midrst_out%0d: adr %0d data %0d expected adr %0d data %0d", k, a_adr[k], a_dat[k], k, exp_a(k));
      end
    end
  endtask

  task automatic test_back_to_back;
    int t; int ndone; int extra; int dt[$];
    for (int i = 0; i < A_IN; i++) begin
      a_in[i] = rnd(-100, 100);
      for (int o = 0; o < A_OUT; o++) a_w[i][o] = rnd(-30, 30);
    end
    for (int o = 0; o < A_OUT; o++) a_b[o] = rnd(-100, 100);
    a_adr.delete(); a_dat.delete();
    @(negedge clk); ifa.start = 1'b1; t = 0; ndone = 0;
    while (ndone < 3 && t < 100) begin
      @(negedge clk); t++;
      if (ifa.done === 1'b1) begin
        ndone++; dt.push_back(t);
        if (ndone == 3) ifa.start = 1'b0;
      end
    end
    ifa.start = 1'b0;
    extra = 0;
    repeat (12) begin @(negedge clk); if (ifa.done === 1'b1) extra++; end
    n_checks++;
    if (ndone != 3 || extra != 0 || ifa.busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_count: dones %0d extra %0d busy %b expected 3 0 0", ndone, extra, ifa.busy);
    end
    for (int p = 0; p < dt.size(); p++) begin
      n_checks++;
      if (dt[p] != 8 + 9 * p) begin n_fail++; $display("FAIL b2b_done%0d: cycle %0d expected %0d", p, dt[p], 8 + 9 * p); end
    end
    n_checks++;
    if (a_adr.size() != 3 * A_OUT) begin n_fail++; $display("FAIL b2b_writes: got %0d expected %0d", a_adr.size(), 3 * A_OUT); end
    for (int k = 0; k < a_adr.size() && k < 3 * A_OUT; k++) begin
      n_checks++;
      if (a_adr[k] != k % A_OUT || a_dat[k] != exp_a(k % A_OUT)) begin
        n_fail++; $display("FAIL b2b_out%0d: adr %0d data %0d expected adr %0d data %0d", k, a_adr[k], a_dat[k], k % A_OUT, exp_a(k % A_OUT));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_negative();
    test_random_a();
    test_saturation();
    test_groups();
    test_single_input();
    test_reset_mid_pass();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_engine.md
DENSE_ENGINE -- requirements
Module: dense_engine

Interface
REQ-001 SHALL have parameter IN_COUNT, default 784, meaning number of input activations.
REQ-002 SHALL have parameter OUT_COUNT, default 10, meaning number of output neurons.
REQ-003 SHALL have parameter DATA_SIZE, default 16, meaning signed two's-complement width of activations, weights and biases.
REQ-004 SHALL have parameter LANES, default 2, meaning parallel MAC lanes; OUT_COUNT divisible by LANES; GROUPS = OUT_COUNT/LANES.
REQ-005 SHALL have parameter FRAC_BITS, default 8, meaning fixed-point fraction bits removed at output.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to begin a layer pass.
REQ-009 busy  out  1  high from the cycle after accepted start until done.
REQ-010 done  out  1  one-cycle pulse after the last output write.
REQ-011 inAdr  out  clog2(IN_COUNT)  input buffer address; inData  in  DATA_SIZE  combinational read data.
REQ-012 weightAdr  out  clog2(IN_COUNT*GROUPS)  weight LUT address; weightData  in  LANES*DATA_SIZE  lane l in bits [l*DATA_SIZE +: DATA_SIZE].
REQ-013 biasAdr  out  clog2(GROUPS)  bias LUT address; biasData  in  LANES*DATA_SIZE  same lane packing.
REQ-014 outAdr  out  clog2(OUT_COUNT); outData  out  DATA_SIZE; outWr  out  1  output buffer write strobe.

Function
REQ-015 FSM states SHALL be IDLE, MAC, BIAS, WRITE, FIN.
REQ-016 IDLE: start=1 SHALL clear group, input and lane counters and all lane accumulators, go to MAC; start SHALL be ignored in all other states.
REQ-017 MAC: each cycle lane l SHALL add inData*weightData[l] to its accumulator, with inAdr = input counter, weightAdr = input*GROUPS + group; after IN_COUNT cycles go to BIAS.
REQ-018 BIAS: one cycle, biasAdr = group, each lane SHALL add sign-extended biasData[l]; go to WRITE.
REQ-019 WRITE: LANES cycles, cycle k SHALL assert outWr with outAdr = group*LANES + k and outData = post-processed lane k accumulator.
REQ-020 After WRITE, if group < GROUPS-1 SHALL increment group, clear accumulators and input counter, return to MAC; else go to FIN.
REQ-021 FIN: SHALL assert done for one cycle, deassert busy, return to IDLE.
REQ-022 Total latency start to done SHALL be GROUPS*(IN_COUNT+1+LANES)+1 cycles.
REQ-023 Accumulator width SHALL be 2*DATA_SIZE + clog2(IN_COUNT) + 1 signed bits; no overflow within one pass.
REQ-024 Post-processing SHALL arithmetic-shift-right by FRAC_BITS (truncate toward minus infinity), then saturate to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
REQ-025 outWr SHALL be low in every state except WRITE; address outputs outside their active state are don't-care.
REQ-026 IN_COUNT=1 and LANES=OUT_COUNT (GROUPS=1) SHALL be supported without special casing.

Reset
REQ-027 rst SHALL force IDLE, clear all counters and accumulators, busy=0, done=0, outWr=0, overriding start in the same cycle.
REQ-028 rst asserted mid-pass SHALL abort with no further outWr; the next start SHALL begin a fresh pass.

Configuration
REQ-029 With macro DENSE_ENGINE_RELU_EN defined, post-processing SHALL clamp negative results to 0 after saturation.
REQ-030 Without DENSE_ENGINE_RELU_EN, signed saturated results SHALL be written unchanged.

Verification
REQ-031 IN_COUNT=4, OUT_COUNT=2, LANES=2, FRAC_BITS=0, inputs 1,2,3,4, weights all 1, bias 5 -> outWr at adr 0,1 both data 15, done exactly 8 cycles after start (latency 1*(4+1+2)+1 = 8, matching REQ-022).
REQ-032 Same setup, weights -1, bias 0, no DENSE_ENGINE_RELU_EN -> data -10; with macro -> data 0.
REQ-033 DATA_SIZE=8, FRAC_BITS=0, inputs 127, weights 127, IN_COUNT=4 -> outData saturates to 127; negated weights -> -128.
REQ-034 OUT_COUNT=4, LANES=2 -> writes in order adr 0,1,2,3; accumulators cleared between groups (group 1 result independent of group 0).
REQ-035 rst pulsed during MAC of group 0 -> no outWr, busy=0 next cycle; following start yields full correct result set.
REQ-036 start held high continuously -> passes run back-to-back, one done per pass, start during busy never restarts counters.
